// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- bundle of the fetch unit's external handshakes.
//   Cache side : inst_req/inst_addr (to cache), inst_valid/inst_data (from cache)
//   Decode side: dec_valid/dec_inst/dec_pc (to decode), dec_ready (from decode)
//   Control    : redirect/redirect_pc (from branch resolution), q_level (status)
// Modport master is the fetch unit; modport slave is its surroundings.
interface fetch_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = 3
);
    logic                  inst_req;
    logic [DATA_WIDTH-1:0] inst_addr;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst_data;
    logic                  dec_valid;
    logic                  dec_ready;
    logic [DATA_WIDTH-1:0] dec_inst;
    logic [DATA_WIDTH-1:0] dec_pc;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [LVL_W-1:0]      q_level;

    modport master (
        output inst_req, inst_addr,
        input  inst_valid, inst_data,
        output dec_valid, dec_inst, dec_pc,
        input  dec_ready,
        input  redirect, redirect_pc,
        output q_level
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_valid, inst_data,
        input  dec_valid, dec_inst, dec_pc,
        output dec_ready,
        output redirect, redirect_pc,
        input  q_level
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- prefetching instruction fetch unit.
// Issues sequential cache requests ahead of decode and buffers each response,
// tagged with its PC, in a QUEUE_DEPTH-entry FIFO that decode drains through a
// valid/ready handshake. A redirect empties the queue, discards the response
// still in flight and restarts fetch at redirect_pc.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_queue_if.master (cache request/response, decode handshake,
//          redirect, q_level occupancy)
//   stat_fetched / stat_flushed - present only when FETCH_STATS_EN is defined:
//          instructions handed to decode, and entries/responses thrown away
//          by redirects.
// Optional feature macro: FETCH_STATS_EN.
module fetch_queue #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] START_ADDR  = 32'h00000000,
    parameter int                    PC_STEP     = 1,
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    LVL_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]    stat_fetched,
    output logic [31:0]    stat_flushed
`endif
);
    localparam int                    PTR_W   = $clog2(QUEUE_DEPTH);
    localparam logic [LVL_W-1:0]      DEPTH_L = LVL_W'(QUEUE_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP_L  = DATA_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                  state_reg;
    logic                    inst_req_reg;
    logic [DATA_WIDTH-1:0]   inst_addr_reg;
    logic [DATA_WIDTH-1:0]   fetch_pc_reg;
    logic [LVL_W-1:0]        count_reg;
    logic [LVL_W-1:0]        count_next;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_next;
    logic                    dec_valid_reg;
    logic [DATA_WIDTH-1:0]   head_inst_reg;
    logic [DATA_WIDTH-1:0]   head_pc_reg;
    logic [2*DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic                    push;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   pc_plus;

    assign pop     = dec_valid_reg & bus.dec_ready;
    // Only a response to a live (non-dropped) request enters the queue.
    assign push    = (state_reg == REQ) & bus.inst_valid & ~bus.redirect;
    assign pc_plus = fetch_pc_reg + STEP_L;

    // Occupancy after this cycle's push/pop (redirect handled separately).
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + LVL_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - LVL_W'(1);
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (bus.redirect) begin
            rd_ptr_next = '0;
        end else if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
    end

    // Queue storage: plain array, written on push, read into a head register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {fetch_pc_reg, bus.inst_data};
        end
    end

    // Registered head read. When the slot being written is the one that
    // becomes the head (queue empty after this cycle's pop), forward the
    // incoming response, since the array still holds stale data this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_inst_reg <= '0;
            head_pc_reg   <= '0;
        end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_inst_reg <= bus.inst_data;
            head_pc_reg   <= fetch_pc_reg;
        end else begin
            {head_pc_reg, head_inst_reg} <= mem[rd_ptr_next];
        end
    end

    // Request FSM and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            inst_req_reg  <= 1'b0;
            inst_addr_reg <= START_ADDR;
            fetch_pc_reg  <= START_ADDR;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            dec_valid_reg <= 1'b0;
        end else if (bus.redirect) begin
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            dec_valid_reg <= 1'b0;
            fetch_pc_reg  <= bus.redirect_pc;
            case (state_reg)
                IDLE: begin
                    state_reg     <= REQ;
                    inst_req_reg  <= 1'b1;
                    inst_addr_reg <= bus.redirect_pc;
                end
                REQ, DROP: begin
                    // A response arriving now is simply discarded and the new
                    // request can start at once; otherwise the old request is
                    // still owed a response, which DROP waits out.
                    if (bus.inst_valid) begin
                        state_reg     <= REQ;
                        inst_addr_reg <= bus.redirect_pc;
                    end else begin
                        state_reg     <= DROP;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    inst_req_reg <= 1'b0;
                end
            endcase
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            dec_valid_reg <= (count_next != '0);
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                fetch_pc_reg <= pc_plus;
            end
            case (state_reg)
                IDLE: begin
                    if (count_next < DEPTH_L) begin
                        state_reg     <= REQ;
                        inst_req_reg  <= 1'b1;
                        inst_addr_reg <= fetch_pc_reg;
                    end
                end
                REQ: begin
                    if (bus.inst_valid) begin
                        if (count_next < DEPTH_L) begin
                            inst_addr_reg <= pc_plus;
                        end else begin
                            state_reg    <= IDLE;
                            inst_req_reg <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.inst_valid) begin
                        state_reg     <= REQ;
                        inst_addr_reg <= fetch_pc_reg;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    inst_req_reg <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Requests are only raised with room left, so a full-queue push is a bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (count_reg == DEPTH_L)));
        end
    end
`endif

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_reg;
    logic [31:0] flushed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_reg <= '0;
            flushed_reg <= '0;
        end else if (bus.redirect) begin
            // A response still owed in REQ is discarded (now or via DROP);
            // in DROP it was already counted by the redirect that entered DROP.
            flushed_reg <= flushed_reg + 32'(count_reg)
                         + ((state_reg == REQ) ? 32'd1 : 32'd0);
        end else if (pop) begin
            fetched_reg <= fetched_reg + 32'd1;
        end
    end

    assign stat_fetched = fetched_reg;
    assign stat_flushed = flushed_reg;
`endif

    assign bus.inst_req  = inst_req_reg;
    assign bus.inst_addr = inst_addr_reg;
    assign bus.dec_valid = dec_valid_reg;
    assign bus.dec_inst  = head_inst_reg;
    assign bus.dec_pc    = head_pc_reg;
    assign bus.q_level   = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- self-checking bench for fetch_queue.
// A 2-cycle-latency cache model answers requests; a scoreboard queue holds the
// {pc, inst} pairs decode must see, pushed when an accepted response is driven
// and popped when decode takes the head. A table of phases drives the main
// stream; hand-written sequences cover the redirect and reset corner cases.
module tb_fetch_queue;
    localparam int          DW    = 32;
    localparam logic [31:0] START = 32'h0000_0100;
    localparam int          STEP  = 4;
    localparam int          QD    = 4;
    localparam int          LVL_W = $clog2(QD + 1);
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if #(.DATA_WIDTH(DW), .LVL_W(LVL_W)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    fetch_queue #(
        .DATA_WIDTH (DW),
        .START_ADDR (START),
        .PC_STEP    (STEP),
        .QUEUE_DEPTH(QD),
        .LVL_W      (LVL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_flushed(stat_flushed)
`endif
    );

    typedef struct {
        int          n;       // cycles to apply
        logic        rdy;     // dec_ready
        logic        stall;   // hold cache response back
        logic        rdr;     // redirect on the first cycle
        logic [31:0] rpc;
        logic        chk;     // compare level/req at end of phase
        int          lvl;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
    } phase_t;

    logic [63:0] sb[$];
    logic [31:0] model_pc;
    logic        drop_pending;
    int          cache_cnt;
    int          pop_cnt;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle(input logic rdy, input logic stall, input logic rdr,
                         input logic [31:0] rpc, input logic rst_in);
        logic [63:0] e;
        check("q_level", 64'(bus.q_level), 64'(sb.size()));
        check("dec_valid", 64'(bus.dec_valid), 64'(sb.size() != 0));
        rst             = rst_in;
        bus.dec_ready   = rdy;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        // cache model
        if (rst_in || !bus.inst_req) begin
            bus.inst_valid = 1'b0;
            cache_cnt      = 0;
        end else if (stall) begin
            bus.inst_valid = 1'b0;
        end else if (cache_cnt == LAT - 1) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = inst_of(bus.inst_addr);
            cache_cnt      = 0;
        end else begin
            bus.inst_valid = 1'b0;
            cache_cnt++;
        end
        // reference model / scoreboard
        if (rst_in) begin
            sb.delete();
            model_pc     = START;
            drop_pending = 1'b0;
        end else if (rdr) begin
            sb.delete();
            model_pc     = rpc;
            drop_pending = bus.inst_req && !bus.inst_valid;
        end else begin
            if (bus.dec_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("dec_valid_extra", 64'(bus.dec_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("dec_pc", 64'(bus.dec_pc), 64'(e[63:32]));
                    check("dec_inst", 64'(bus.dec_inst), 64'(e[31:0]));
                    pop_cnt++;
                end
            end
            if (bus.inst_valid) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    check("inst_addr", 64'(bus.inst_addr), 64'(model_pc));
                    sb.push_back({model_pc, inst_of(model_pc)});
                    model_pc = model_pc + STEP;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    phase_t ph[5];

    initial begin
        n_vec = 0; n_err = 0; pop_cnt = 0; cache_cnt = 0;
        model_pc = START; drop_pending = 1'b0;
        bus.inst_valid = 1'b0; bus.inst_data = '0; bus.dec_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;

        //            n   rdy  stall rdr  rpc           chk  lvl req  chk_addr addr
        ph[0] = '{12, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4, 1'b0, 1'b0, 32'h0};
        ph[1] = '{1,  1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 3, 1'b1, 1'b1, 32'h110};
        ph[2] = '{40, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 0, 1'b0, 1'b0, 32'h0};
        ph[3] = '{1,  1'b1, 1'b1, 1'b1, 32'h400,      1'b1, 0, 1'b1, 1'b0, 32'h0};
        ph[4] = '{10, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 0, 1'b0, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inst_req", 64'(bus.inst_req), 64'd0);
        check("rst_inst_addr", 64'(bus.inst_addr), 64'(START));
        check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("rst_dec_inst", 64'(bus.dec_inst), 64'd0);
        check("rst_dec_pc", 64'(bus.dec_pc), 64'd0);
        check("rst_q_level", 64'(bus.q_level), 64'd0);

        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ph[p].n; c++) begin
                cycle(ph[p].rdy, ph[p].stall, ph[p].rdr && (c == 0), ph[p].rpc, 1'b0);
            end
            if (ph[p].chk) begin
                check($sformatf("phase%0d_level", p), 64'(bus.q_level), 64'(ph[p].lvl));
                check($sformatf("phase%0d_req", p), 64'(bus.inst_req), 64'(ph[p].req));
            end
            if (ph[p].chk_addr) begin
                check($sformatf("phase%0d_addr", p), 64'(bus.inst_addr), 64'(ph[p].addr));
            end
        end

        // Redirect coinciding with a response and a pop, 2 entries queued.
        for (int i = 0; i < 50 && !(sb.size() == 2 && bus.inst_req && cache_cnt == LAT - 1); i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("wait_two_queued", 64'(sb.size() == 2 && bus.inst_req && cache_cnt == LAT - 1), 64'd1);
        cycle(1'b1, 1'b0, 1'b1, 32'h800, 1'b0);
        check("redir800_level", 64'(bus.q_level), 64'd0);
        check("redir800_addr", 64'(bus.inst_addr), 64'h800);
        for (int i = 0; i < 20 && !bus.dec_valid; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("redir800_first_pc", 64'(bus.dec_pc), 64'h800);
        for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset mid-stream with 3 entries queued.
        for (int i = 0; i < 50 && sb.size() != 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("wait_three_queued", 64'(sb.size()), 64'd3);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("midrst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("midrst_q_level", 64'(bus.q_level), 64'd0);
        check("midrst_inst_addr", 64'(bus.inst_addr), 64'(START));
        check("midrst_inst_req", 64'(bus.inst_req), 64'd0);
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef FETCH_STATS_EN
        begin
            int exp_fl;
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            pop_cnt = 0;
            for (int i = 0; i < 60 && pop_cnt < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            check("stats_wait_pops", 64'(pop_cnt), 64'd5);
            for (int i = 0; i < 50 && !(sb.size() == 2 && bus.inst_req); i++) begin
                cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            end
            exp_fl = sb.size() + 1;
            cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
            check("stat_fetched", 64'(stat_fetched), 64'(pop_cnt));
            check("stat_flushed", 64'(stat_flushed), 64'(exp_fl));
        end
`endif

        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Prefetching fetch unit; successor to the single-outstanding, FSM-stepped fetch stage.
- Issues sequential instruction-cache requests ahead of decode and buffers responses in a parametrised FIFO, tagged with their PC.
- Decode consumes through a valid/ready handshake.
- A redirect (taken branch/jump) flushes the queue, discards any in-flight response and restarts fetch at the new PC.

Parameters:
- DATA_WIDTH, 32, instruction width and address width.
- START_ADDR, 32'h00000000, fetch PC after reset.
- PC_STEP, 1, increment added to fetch PC per accepted instruction (1 = word addressing, 4 = byte addressing).
- QUEUE_DEPTH, 4, FIFO entries; power of two, >= 2.
- LVL_W, $clog2(QUEUE_DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  out  1  cache request, registered level
- inst_addr  out  DATA_WIDTH  request address, stable while inst_req=1
- inst_valid  in  1  single-cycle response strobe; only while inst_req=1
- inst_data  in  DATA_WIDTH  response data, qualified by inst_valid
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode accepts head
- dec_inst  out  DATA_WIDTH  head instruction
- dec_pc  out  DATA_WIDTH  head PC
- redirect  in  1  flush and restart request, single cycle
- redirect_pc  in  DATA_WIDTH  restart PC, qualified by redirect
- q_level  out  LVL_W  current queue occupancy

Behaviour:
- Reset, rst=1 sampled at an edge:
  - inst_req=0, inst_addr=START_ADDR, fetch PC=START_ADDR.
  - dec_valid=0, dec_inst=0, dec_pc=0, q_level=0.
  - FSM to IDLE.
  - Applies mid-operation too: queue emptied, outstanding response forgotten. The cache is cleared by the same reset.
- FSM states:
  - IDLE: no request outstanding. If count < QUEUE_DEPTH and no redirect, go to REQ and set inst_req=1. First request is therefore visible 1 cycle after reset release.
  - REQ: inst_req=1, inst_addr=fetch PC. On inst_valid (no redirect):
    - Push {fetch PC, inst_data}; fetch PC += PC_STEP (modulo 2^DATA_WIDTH).
    - If count after push and pop < QUEUE_DEPTH, stay in REQ with the new address: back-to-back requests, inst_req stays high.
    - Otherwise go to IDLE with inst_req=0.
  - DROP: a redirect arrived while in REQ without inst_valid. inst_req stays high at the old address. On inst_valid, discard the data and go to REQ at the new PC (inst_req stays high).
- Redirect, highest priority after rst:
  - Queue count=0 at the next edge; any same-cycle pop or push is ignored; fetch PC <= redirect_pc.
  - From IDLE: go to REQ.
  - From REQ with inst_valid the same cycle: data discarded, go to REQ at redirect_pc.
  - From REQ without inst_valid: go to DROP.
  - From DROP: stay in DROP with the updated PC.
- Queue:
  - Pop when dec_valid & dec_ready.
  - Push appears at the head no earlier than the next cycle; no same-cycle bypass.
  - Simultaneous push and pop keeps count unchanged.
  - Read/write pointers wrap modulo QUEUE_DEPTH.
  - Requests are issued only when count < QUEUE_DEPTH, so a push into a full queue is impossible. If one occurs, assert via a simulation-only check.
  - dec_inst/dec_pc are don't-care while dec_valid=0.
- Ordering: dec_pc values follow fetch order; each equals the previous + PC_STEP except across a redirect.
- q_level equals count; registered.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds output ports stat_fetched[31:0] and stat_flushed[31:0], both reset to 0 and wrapping.
  - stat_fetched increments per pop.
  - stat_flushed adds the number of entries discarded by a redirect, plus 1 if an in-flight response is discarded.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- START_ADDR=0x100, PC_STEP=4, cache latency 2, dec_ready=1 -> inst_addr sequence 0x100, 0x104, 0x108…; dec_pc/dec_inst pairs match, in order, with no gaps.
- QUEUE_DEPTH=4, dec_ready=0 -> exactly 4 responses accepted, then inst_req=0 and q_level=4 held. Raise dec_ready for 1 cycle -> q_level=3 and a new request at the next address.
- Redirect to 0x400 while in REQ with no response yet -> response for the old address dropped (never on dec_*); next request at 0x400; q_level=0 the cycle after the redirect.
- Redirect to 0x800 in the same cycle as inst_valid and dec_ready with 2 entries queued -> neither pop nor push takes effect; q_level=0; first dec_pc seen afterwards = 0x800.
- rst pulsed mid-stream with 3 entries queued -> dec_valid=0, q_level=0, inst_addr=START_ADDR; fetch resumes from START_ADDR.
- FETCH_STATS_EN defined: 5 pops, then a redirect with 2 queued plus 1 in-flight -> stat_fetched=5, stat_flushed=3.
